keypad_digit_entry: RTL and testbench
=====================================

Name: keypad_digit_entry

Overview:
- Sequential consumer of the keypad priority encoder outputs (4-bit digit code plus all-keys-released flag).
- Debounces key press and release, and emits exactly one accepted digit per physical press.
- Shifts accepted digits into a BCD time-entry register for the microwave timer.
- Sits between the keypad encoder and the timer/display control logic.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive identical samples required to accept a press or a release. Legal range 2..255.
- DIGITS, 4: number of BCD digits held in the entry register. Legal range 1..7.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- enablen  input  1  active-low entry enable; 1 blocks new presses.
- D  input  4  encoded digit from keypad encoder.
- all_off  input  1  1 when no key is pressed.
- clear_entry  input  1  synchronous clear of the entry register and digit count.
- digit_valid  output  1  one-cycle pulse when a digit is accepted.
- digit_out  output  4  last accepted digit; held between accepts.
- time_bcd  output  4*DIGITS  entry register; digit 0 is bits [3:0], most recently entered.
- count  output  3  digits entered, saturating at DIGITS.
- entry_full  output  1  high when count == DIGITS.

Behaviour:
- Reset: synchronous, sampled on the clk edge. Effects:
  - FSM goes to IDLE; debounce counter and candidate go to 0.
  - digit_valid=0, digit_out=0, time_bcd=0, count=0, entry_full=0.
  - Reset overrides every other input, including mid-debounce.
- Valid press: a sample with all_off=0 and D<=9. A sample with D>9 is treated as no key.
- FSM states: IDLE, PRESS_DB, HELD, REL_DB.
- IDLE:
  - On a valid press with enablen=0: candidate<=D, cnt<=1, go to PRESS_DB.
  - Otherwise stay in IDLE.
- PRESS_DB:
  - If enablen=1, or all_off=1, or D != candidate: go to IDLE, cnt<=0, nothing accepted.
  - Otherwise cnt<=cnt+1.
  - On the edge where the matching sample is the DEBOUNCE_CYCLES-th consecutive one: accept and go to HELD.
- Accept (registered outputs, all on the same edge):
  - time_bcd <= {time_bcd[4*DIGITS-5:0], candidate}; the oldest digit is discarded (wrap-around).
  - digit_out <= candidate; digit_valid <= 1 for exactly one cycle.
  - count <= min(count+1, DIGITS).
- Latency: the first valid sample is taken at edge k. The accept is registered at edge k+DEBOUNCE_CYCLES-1, so the outputs are visible in the following cycle.
- HELD:
  - Stay in HELD while all_off=0. A D change while held is ignored: no second accept, no rollover.
  - all_off=1: cnt<=1, go to REL_DB.
- REL_DB:
  - all_off=0: go to HELD, cnt<=0.
  - After DEBOUNCE_CYCLES consecutive all_off=1 samples: go to IDLE.
  - enablen does not affect HELD or REL_DB; this prevents re-acceptance when the enable is toggled during a hold.
- clear_entry:
  - Sets time_bcd=0, count=0, entry_full=0 on the next edge.
  - If it coincides with an accept edge: clear wins, the digit is dropped, and digit_valid stays 0. The FSM still advances to HELD.
  - digit_out and the FSM are otherwise unaffected.
- Full condition:
  - entry_full = (count == DIGITS).
  - Further accepts still shift in and wrap; count stays at DIGITS.
- digit_valid is 0 in every cycle except the one following an accept edge.

Test Plan:
- Reset, then press key 5 (D=5, all_off=0) for 10 cycles, then release for 10 cycles. Required: exactly one digit_valid pulse, 4 cycles after the first sample; time_bcd=16'h0005; count=1; digit_out=5.
- Enter 1, 2, 3, 0 with clean press/release pairs. Required: time_bcd=16'h1230 and entry_full=1. A fifth digit 7 must give time_bcd=16'h2307, count=4.
- Bounce: D=3 with all_off toggling 0,1,0,0,1 over 5 cycles, then stable for 6 cycles. Required: one accept of 3, timed from the start of the stable run.
- Glitch on release: hold 4 until accepted, then all_off=1 for 2 cycles, 0 for 1 cycle, 1 for 6 cycles. Required: no second accept, and the FSM returns to IDLE.
- Assert clear_entry on the exact accept edge of digit 9 while time_bcd=16'h0012. Required: time_bcd=0, count=0, digit_valid stays 0. A later press of 8 gives 16'h0008.
- Hold enablen=1 with D=6 pressed for 20 cycles. Required: no accept. Toggle enablen to 0 while still held → accept 6 after 4 cycles. Assert reset during PRESS_DB → all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/keypad_digit_entry.sv
// keypad_digit_entry
//   Debounces keypad press/release events from the priority encoder and
//   accepts exactly one digit per physical press. Accepted digits are
//   shifted into a BCD time-entry register for the microwave timer.
//
//   Parameters
//     DEBOUNCE_CYCLES  consecutive identical samples needed for press/release (2..255)
//     DIGITS           BCD digits held in the entry register (1..7)
//
//   Ports
//     clk          system clock, rising edge
//     reset        synchronous active-high reset
//     enablen      active-low entry enable; 1 blocks new presses
//     D            encoded digit from keypad encoder (>9 means no key)
//     all_off      1 when no key is pressed
//     clear_entry  synchronous clear of entry register and digit count
//     digit_valid  one-cycle pulse after a digit is accepted
//     digit_out    last accepted digit, held between accepts
//     time_bcd     entry register, digit 0 in [3:0] is the newest
//     count        digits entered, saturates at DIGITS
//     entry_full   count == DIGITS
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   IDLE     | no key held, waiting for a valid enabled press
//   PRESS_DB | counting identical samples of the candidate digit
//   HELD     | digit accepted, waiting for release
//   REL_DB   | counting consecutive released samples
module keypad_digit_entry #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DIGITS          = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enablen,
  input  logic [3:0]            D,
  input  logic                  all_off,
  input  logic                  clear_entry,
  output logic                  digit_valid,
  output logic [3:0]            digit_out,
  output logic [4*DIGITS-1:0]   time_bcd,
  output logic [2:0]            count,
  output logic                  entry_full
);

  localparam int         W        = 4 * DIGITS;
  localparam logic [7:0] DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] DIGITS_C = 3'(DIGITS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [3:0]   cand_q, cand_d;
  logic         valid_q, valid_d;
  logic [3:0]   dout_q, dout_d;
  logic [W-1:0] bcd_q, bcd_d;
  logic [2:0]   count_q, count_d;

  logic         valid_press;
  logic         accept;
  logic [W-1:0] shifted;

  // Codes above 9 come from the encoder when no digit key is down.
  assign valid_press = !all_off && (D <= 4'd9);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_press && !enablen) begin
          cand_d  = D;
          cnt_d   = 8'd1;
          state_d = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (enablen || all_off || (D != cand_q)) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q >= DB_LAST) begin
          // This sample is the DEBOUNCE_CYCLES-th matching one.
          accept  = 1'b1;
          state_d = HELD;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HELD: begin
        // enablen is deliberately ignored so toggling it mid-hold
        // cannot re-arm a second accept of the same press.
        if (all_off) begin
          cnt_d   = 8'd1;
          state_d = REL_DB;
        end
      end
      REL_DB: begin
        if (!all_off) begin
          state_d = HELD;
          cnt_d   = 8'd0;
        end else if (cnt_q >= DB_LAST) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_comb begin
    valid_d    = 1'b0;
    dout_d     = dout_q;
    bcd_d      = bcd_q;
    count_d    = count_q;
    // Shift-and-insert written without a part-select so DIGITS=1 is legal.
    shifted      = bcd_q << 4;
    shifted[3:0] = cand_q;
    if (clear_entry) begin
      // Clear beats a coincident accept: that digit is dropped entirely.
      bcd_d   = '0;
      count_d = 3'd0;
    end else if (accept) begin
      bcd_d   = shifted;
      dout_d  = cand_q;
      valid_d = 1'b1;
      count_d = (count_q >= DIGITS_C) ? DIGITS_C : count_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      cand_q  <= 4'd0;
      valid_q <= 1'b0;
      dout_q  <= 4'd0;
      bcd_q   <= '0;
      count_q <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      valid_q <= valid_d;
      dout_q  <= dout_d;
      bcd_q   <= bcd_d;
      count_q <= count_d;
    end
  end

  assign digit_valid = valid_q;
  assign digit_out   = dout_q;
  assign time_bcd    = bcd_q;
  assign count       = count_q;
  assign entry_full  = (count_q == DIGITS_C);

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Directed bench for keypad_digit_entry with a scoreboard: stimulus pushes
// the expected accept (digit, register contents, count, full flag and the
// cycle at which the pulse must appear); a monitor pops on every
// digit_valid pulse and compares.
module tb_keypad_digit_entry;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enablen;
  logic [3:0]  D;
  logic        all_off;
  logic        clear_entry;
  logic        digit_valid;
  logic [3:0]  digit_out;
  logic [15:0] time_bcd;
  logic [2:0]  count;
  logic        entry_full;

  keypad_digit_entry #(.DEBOUNCE_CYCLES(DB), .DIGITS(4)) dut (
    .clk(clk), .reset(reset), .enablen(enablen), .D(D), .all_off(all_off),
    .clear_entry(clear_entry), .digit_valid(digit_valid), .digit_out(digit_out),
    .time_bcd(time_bcd), .count(count), .entry_full(entry_full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  digit;
    logic [15:0] bcd;
    logic [2:0]  cnt;
    logic        full;
    int          when;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every accept pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (digit_valid !== 1'b0) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_accept: got digit_valid=%b digit %0d at cycle %0d, expected no accept",
                 digit_valid, digit_out, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("accept_digit", 32'(digit_out), 32'(e.digit));
        check("accept_bcd",   32'(time_bcd),  32'(e.bcd));
        check("accept_count", 32'(count),     32'(e.cnt));
        check("accept_full",  32'(entry_full), 32'(e.full));
        check("accept_cycle", 32'(cyc),       32'(e.when));
      end
    end
  end

  task automatic release_key();
    D = 4'hF;
    all_off = 1'b1;
  endtask

  // Called at a negedge: present key d, expect its accept DB cycles later.
  task automatic press(input logic [3:0] d, input logic [15:0] bcd, input logic [2:0] cnt,
                       input logic full, input int hold, input int rel);
    exp_t e;
    D = d;
    all_off = 1'b0;
    e.digit = d;
    e.bcd = bcd;
    e.cnt = cnt;
    e.full = full;
    e.when = cyc + DB;
    sb.push_back(e);
    repeat (hold) @(negedge clk);
    release_key();
    repeat (rel) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(digit_valid), 32'd0);
    check({tag, "_dout"},  32'(digit_out),   32'd0);
    check({tag, "_bcd"},   32'(time_bcd),    32'd0);
    check({tag, "_count"}, 32'(count),       32'd0);
    check({tag, "_full"},  32'(entry_full),  32'd0);
  endtask

  initial begin
    int bounce [5] = '{0, 1, 0, 0, 1};
    reset = 1'b1;
    enablen = 1'b0;
    clear_entry = 1'b0;
    release_key();
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Single press of 5
    press(4'd5, 16'h0005, 3'd1, 1'b0, 10, 10);
    check("k5_bcd",   32'(time_bcd),  32'h0005);
    check("k5_count", 32'(count),     32'd1);
    check("k5_dout",  32'(digit_out), 32'd5);

    // Fill and wrap
    press(4'd1, 16'h0051, 3'd2, 1'b0, 6, 6);
    press(4'd2, 16'h0512, 3'd3, 1'b0, 6, 6);
    press(4'd3, 16'h5123, 3'd4, 1'b1, 6, 6);
    press(4'd0, 16'h1230, 3'd4, 1'b1, 6, 6);
    check("fill_bcd",  32'(time_bcd),   32'h1230);
    check("fill_full", 32'(entry_full), 32'd1);
    press(4'd7, 16'h2307, 3'd4, 1'b1, 6, 6);
    check("wrap_bcd",   32'(time_bcd), 32'h2307);
    check("wrap_count", 32'(count),    32'd4);

    // Bouncy press of 3; accept is timed from the start of the stable run
    D = 4'd3;
    foreach (bounce[i]) begin
      all_off = bounce[i][0];
      @(negedge clk);
    end
    press(4'd3, 16'h3073, 3'd4, 1'b1, 6, 6);

    // Release glitch on key 4, then a fresh press proves the FSM is idle
    press(4'd4, 16'h0734, 3'd4, 1'b1, 6, 0);
    repeat (2) @(negedge clk);
    D = 4'd4;
    all_off = 1'b0;
    @(negedge clk);
    release_key();
    repeat (6) @(negedge clk);
    press(4'd0, 16'h7340, 3'd4, 1'b1, 6, 6);

    // clear_entry coinciding with the accept edge of 9
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    press(4'd1, 16'h0001, 3'd1, 1'b0, 6, 6);
    press(4'd2, 16'h0012, 3'd2, 1'b0, 6, 6);
    check("pre_clr_bcd", 32'(time_bcd), 32'h0012);
    D = 4'd9;
    all_off = 1'b0;
    repeat (DB - 1) @(negedge clk);
    clear_entry = 1'b1;
    @(negedge clk);
    clear_entry = 1'b0;
    check("clr_valid", 32'(digit_valid), 32'd0);
    check("clr_bcd",   32'(time_bcd),    32'd0);
    check("clr_count", 32'(count),       32'd0);
    check("clr_full",  32'(entry_full),  32'd0);
    repeat (3) @(negedge clk);
    release_key();
    repeat (6) @(negedge clk);
    press(4'd8, 16'h0008, 3'd1, 1'b0, 6, 6);

    // Disabled hold of 6, then enable while still held
    enablen = 1'b1;
    D = 4'd6;
    all_off = 1'b0;
    repeat (20) @(negedge clk);
    check("dis_count", 32'(count), 32'd1);
    enablen = 1'b0;
    press(4'd6, 16'h0086, 3'd2, 1'b0, 6, 6);

    // Reset in the middle of PRESS_DB
    D = 4'd7;
    all_off = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    release_key();
    @(negedge clk);
    check_all_zero("rst_mid");
    reset = 1'b0;
    repeat (8) @(negedge clk);

    check("pending_accepts", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
